// File: rtl/frag_write_unit.sv
// rtl/frag_write_unit.sv - fragment writer: clip, optional z-test, colour/depth writes over Avalon-MM.
// Depth test compiled in only when FRAG_ZTEST_EN is defined.
module frag_write_unit #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int FRAC   = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] frame_pointer,
  input  logic [31:0] z_buffer_pointer,
  input  logic        frag_valid,
  output logic        frag_ready,
  input  logic [23:0] frag_rgb,
  input  logic [31:0] frag_x,
  input  logic [31:0] frag_y,
  input  logic [31:0] frag_z,
  output logic [31:0] M_address,
  output logic        M_chipselect,
  output logic        M_read,
  output logic        M_write,
  output logic [31:0] M_writedata,
  input  logic [31:0] M_readdata,
  input  logic        M_readdatavalid,
  input  logic        M_waitrequest,
  output logic        busy,
  output logic [15:0] cnt_written,
  output logic [15:0] cnt_culled,
  output logic [15:0] cnt_clipped
);

`ifdef FRAG_ZTEST_EN
  typedef enum logic [2:0] {IDLE, ZRD, ZWAIT, CWR, ZWR} state_t;
`else
  typedef enum logic [2:0] {IDLE, CWR} state_t;
`endif

  localparam logic signed [31:0] W_S = 32'(WIDTH);
  localparam logic signed [31:0] H_S = 32'(HEIGHT);

  state_t      state_q, state_d;
  logic [31:0] caddr_q;
  logic [23:0] rgb_q;
  logic [15:0] cnt_written_q, cnt_written_d;
  logic [15:0] cnt_clipped_q, cnt_clipped_d;
  logic        inc_written, inc_clipped;

  logic signed [31:0] px, py;
  logic [31:0]        off_c;
  logic               accept, clip;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign px     = $signed(frag_x) >>> FRAC;
  assign py     = $signed(frag_y) >>> FRAC;
  assign clip   = (px < 0) || (py < 0) || (px >= W_S) || (py >= H_S);
  assign off_c  = (py * W_S + px) << 2;

  assign frag_ready = (state_q == IDLE) && !RESET;
  assign accept     = frag_valid && frag_ready;
  assign busy       = (state_q != IDLE);

`ifdef FRAG_ZTEST_EN
  logic [31:0] zaddr_q;
  logic [31:0] z_q;
  logic [15:0] cnt_culled_q, cnt_culled_d;
  logic        inc_culled;
`else
  logic        unused_ztest;
  assign unused_ztest = ^{z_buffer_pointer, frag_z, M_readdata, M_readdatavalid};
`endif

  always_comb begin
    state_d     = state_q;
    inc_written = 1'b0;
    inc_clipped = 1'b0;
`ifdef FRAG_ZTEST_EN
    inc_culled  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (clip) begin
            inc_clipped = 1'b1;
          end else begin
`ifdef FRAG_ZTEST_EN
            state_d = ZRD;
`else
            state_d = CWR;
`endif
          end
        end
      end
`ifdef FRAG_ZTEST_EN
      ZRD: begin
        if (!M_waitrequest) state_d = ZWAIT;
      end
      ZWAIT: begin
        // Equal depth is treated as a failure (strictly nearer wins).
        if (M_readdatavalid) begin
          if ($signed(z_q) < $signed(M_readdata)) begin
            state_d = CWR;
          end else begin
            inc_culled = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      ZWR: begin
        if (!M_waitrequest) state_d = IDLE;
      end
`endif
      CWR: begin
        if (!M_waitrequest) begin
          inc_written = 1'b1;
`ifdef FRAG_ZTEST_EN
          state_d = ZWR;
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cnt_written_d = inc_written ? sat_inc(cnt_written_q) : cnt_written_q;
  assign cnt_clipped_d = inc_clipped ? sat_inc(cnt_clipped_q) : cnt_clipped_q;
`ifdef FRAG_ZTEST_EN
  assign cnt_culled_d  = inc_culled ? sat_inc(cnt_culled_q) : cnt_culled_q;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= IDLE;
      caddr_q       <= 32'h0;
      rgb_q         <= 24'h0;
      cnt_written_q <= 16'h0;
      cnt_clipped_q <= 16'h0;
`ifdef FRAG_ZTEST_EN
      zaddr_q       <= 32'h0;
      z_q           <= 32'h0;
      cnt_culled_q  <= 16'h0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_written_q <= cnt_written_d;
      cnt_clipped_q <= cnt_clipped_d;
`ifdef FRAG_ZTEST_EN
      cnt_culled_q  <= cnt_culled_d;
`endif
      if (accept && !clip) begin
        caddr_q <= frame_pointer + off_c;
        rgb_q   <= frag_rgb;
`ifdef FRAG_ZTEST_EN
        zaddr_q <= z_buffer_pointer + off_c;
        z_q     <= frag_z;
`endif
      end
    end
  end

  // Bus outputs decode only registered state so they hold steady under waitrequest.
  always_comb begin
    M_chipselect = 1'b0;
    M_read       = 1'b0;
    M_write      = 1'b0;
    M_address    = 32'h0;
    M_writedata  = 32'h0;
    case (state_q)
`ifdef FRAG_ZTEST_EN
      ZRD: begin
        M_chipselect = 1'b1;
        M_read       = 1'b1;
        M_address    = zaddr_q;
      end
      ZWR: begin
        M_chipselect = 1'b1;
        M_write      = 1'b1;
        M_address    = zaddr_q;
        M_writedata  = z_q;
      end
`endif
      CWR: begin
        M_chipselect = 1'b1;
        M_write      = 1'b1;
        M_address    = caddr_q;
        M_writedata  = {8'h00, rgb_q};
      end
      default: ;
    endcase
  end

  assign cnt_written = cnt_written_q;
  assign cnt_clipped = cnt_clipped_q;
`ifdef FRAG_ZTEST_EN
  assign cnt_culled  = cnt_culled_q;
`else
  assign cnt_culled  = 16'h0;
`endif

endmodule
